// File: rtl/ysyx_23060240_idu_pipe_if.sv
// IFU -> IDU -> EXU handshake and decoded control bundle.
// The master side feeds instructions and consumes decoded bundles.
interface ysyx_23060240_idu_pipe_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [31:0]     out_inst;
   logic [3:0]      out_alu_func;
   logic            out_w_en;
   logic [2:0]      out_w_sel;
   logic [2:0]      out_branch_type;
   logic            out_jump;
   logic            out_mem_rd_en;
   logic            out_mem_wr_en;
   logic [1:0]      out_mem_size;
   logic            out_mem_unsigned;
   logic            out_csr_en;
   logic            out_ecall;
   logic            out_mret;
   logic            out_is_muldiv;
   logic            out_illegal;
   logic            out_halt;
   logic [31:0]     out_dec_cnt;

   modport master (
      output in_valid, in_inst, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_inst,
      input  out_alu_func, out_w_en, out_w_sel,
      input  out_branch_type, out_jump,
      input  out_mem_rd_en, out_mem_wr_en,
      input  out_mem_size, out_mem_unsigned,
      input  out_csr_en, out_ecall, out_mret,
      input  out_is_muldiv, out_illegal,
      input  out_halt, out_dec_cnt
   );

   modport slave (
      input  in_valid, in_inst, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, out_inst,
      output out_alu_func, out_w_en, out_w_sel,
      output out_branch_type, out_jump,
      output out_mem_rd_en, out_mem_wr_en,
      output out_mem_size, out_mem_unsigned,
      output out_csr_en, out_ecall, out_mret,
      output out_is_muldiv, out_illegal,
      output out_halt, out_dec_cnt
   );
endinterface

// File: rtl/ysyx_23060240_idu_pipe.sv
// Decode stage: DEPTH-entry instruction queue with a combinational
// RV32I/Zicsr(/M) decoder on the head entry.
module ysyx_23060240_idu_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter bit EN_M  = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ysyx_23060240_idu_pipe_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [6:0] OP_LUI   = 7'h37;
   localparam logic [6:0] OP_AUIPC = 7'h17;
   localparam logic [6:0] OP_JAL   = 7'h6f;
   localparam logic [6:0] OP_JALR  = 7'h67;
   localparam logic [6:0] OP_BR    = 7'h63;
   localparam logic [6:0] OP_LD    = 7'h03;
   localparam logic [6:0] OP_ST    = 7'h23;
   localparam logic [6:0] OP_IMM   = 7'h13;
   localparam logic [6:0] OP_REG   = 7'h33;
   localparam logic [6:0] OP_SYS   = 7'h73;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;

   typedef struct packed {
      logic [3:0] alu_func;
      logic       w_en;
      logic [2:0] w_sel;
      logic [2:0] branch_type;
      logic       jump;
      logic       mem_rd_en;
      logic       mem_wr_en;
      logic [1:0] mem_size;
      logic       mem_unsigned;
      logic       csr_en;
      logic       ecall;
      logic       mret;
      logic       is_muldiv;
      logic       illegal;
   } dec_t;

   logic [XLEN-1:0] pc_q   [DEPTH];
   logic [31:0]     inst_q [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            halt;
   logic [31:0]     cnt;
   logic            push;
   logic            pop;
   logic [31:0]     head;
   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   dec_t            dec;

   assign bus.in_ready  = (count < FULL) & ~bus.flush & ~halt;
   assign bus.out_valid = (count != '0) & ~bus.flush & ~halt;
   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Payload storage carries no reset; out_valid qualifies it.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[wr_ptr]   <= bus.in_pc;
         inst_q[wr_ptr] <= bus.in_inst;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halt <= 1'b0;
         cnt  <= '0;
      end else begin
         if (pop) cnt <= cnt + 32'd1;
         if (pop && head == EBREAK) halt <= 1'b1;
      end
   end

   assign head = inst_q[rd_ptr];
   assign opc  = head[6:0];
   assign f3   = head[14:12];
   assign f7   = head[31:25];

   always_comb begin
      dec = '0;
      unique case (1'b1)
         opc == OP_LUI: begin
            dec.w_en     = 1'b1;
            dec.w_sel    = 3'd2;
            dec.alu_func = 4'd14;
         end
         opc == OP_AUIPC: begin
            dec.w_en  = 1'b1;
            dec.w_sel = 3'd2;
         end
         opc == OP_JAL: begin
            dec.w_en  = 1'b1;
            dec.w_sel = 3'd1;
            dec.jump  = 1'b1;
         end
         opc == OP_JALR: begin
            dec.w_en    = 1'b1;
            dec.w_sel   = 3'd1;
            dec.jump    = 1'b1;
            dec.illegal = (f3 != 3'd0);
         end
         opc == OP_BR: begin
            unique case (f3)
               3'd0:    dec.branch_type = 3'd1;
               3'd1:    dec.branch_type = 3'd2;
               3'd4:    dec.branch_type = 3'd3;
               3'd5:    dec.branch_type = 3'd4;
               3'd6:    dec.branch_type = 3'd5;
               3'd7:    dec.branch_type = 3'd6;
               default: dec.illegal     = 1'b1;
            endcase
         end
         opc == OP_LD: begin
            dec.mem_rd_en    = 1'b1;
            dec.w_en         = 1'b1;
            dec.w_sel        = 3'd3;
            dec.mem_size     = f3[1:0];
            dec.mem_unsigned = f3[2];
            dec.illegal      = (f3[1:0] == 2'b11) |
                               (f3[2:1] == 2'b11);
         end
         opc == OP_ST: begin
            dec.mem_wr_en = 1'b1;
            dec.mem_size  = f3[1:0];
            dec.illegal   = f3[2] | (f3[1:0] == 2'b11);
         end
         opc == OP_IMM: begin
            dec.w_en     = 1'b1;
            dec.w_sel    = 3'd2;
            dec.alu_func = {1'b0, f3};
            if (f3 == 3'd1) dec.illegal = (f7 != 7'h00);
            if (f3 == 3'd5) begin
               dec.alu_func[3] = f7[5];
               dec.illegal = (f7 != 7'h00) && (f7 != 7'h20);
            end
         end
         opc == OP_REG: begin
            dec.w_en     = 1'b1;
            dec.w_sel    = 3'd2;
            dec.alu_func = {1'b0, f3};
            if (f7 == 7'h01) begin
               dec.is_muldiv = EN_M;
               dec.illegal   = !EN_M;
            end else if (f7 == 7'h20) begin
               dec.alu_func[3] = 1'b1;
               dec.illegal = (f3 != 3'd0) && (f3 != 3'd5);
            end else begin
               dec.illegal = (f7 != 7'h00);
            end
         end
         opc == OP_SYS: begin
            if (head == ECALL) begin
               dec.ecall = 1'b1;
            end else if (head == MRET) begin
               dec.mret = 1'b1;
            end else if (head == EBREAK) begin
               dec.illegal = 1'b0;
            end else if (f3 == 3'd1) begin
               dec.csr_en   = 1'b1;
               dec.w_en     = 1'b1;
               dec.w_sel    = 3'd4;
               dec.alu_func = 4'd8;
            end else if (f3 == 3'd2) begin
               dec.csr_en   = 1'b1;
               dec.w_en     = 1'b1;
               dec.w_sel    = 3'd4;
               dec.alu_func = 4'd6;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         default: dec.illegal = 1'b1;
      endcase
      // An illegal head must not trigger any side effect downstream.
      if (dec.illegal) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
   end

   assign bus.out_pc           = pc_q[rd_ptr];
   assign bus.out_inst         = head;
   assign bus.out_alu_func     = dec.alu_func;
   assign bus.out_w_en         = dec.w_en;
   assign bus.out_w_sel        = dec.w_sel;
   assign bus.out_branch_type  = dec.branch_type;
   assign bus.out_jump         = dec.jump;
   assign bus.out_mem_rd_en    = dec.mem_rd_en;
   assign bus.out_mem_wr_en    = dec.mem_wr_en;
   assign bus.out_mem_size     = dec.mem_size;
   assign bus.out_mem_unsigned = dec.mem_unsigned;
   assign bus.out_csr_en       = dec.csr_en;
   assign bus.out_ecall        = dec.ecall;
   assign bus.out_mret         = dec.mret;
   assign bus.out_is_muldiv    = dec.is_muldiv;
   assign bus.out_illegal      = dec.illegal;
   assign bus.out_halt         = halt;
   assign bus.out_dec_cnt      = cnt;
endmodule

// File: tb/tb_ysyx_23060240_idu_pipe.sv
// Bench for the decode stage: directed steps plus random traffic
// against a queue-and-rules reference model (EN_M=0 and EN_M=1 copies).
module tb_ysyx_23060240_idu_pipe;
   localparam int XLEN  = 32;
   localparam int DEPTH = 2;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef struct packed {
      logic [3:0] alu;
      logic       w_en;
      logic [2:0] w_sel;
      logic [2:0] br;
      logic       jump;
      logic       rd;
      logic       wr;
      logic [1:0] size;
      logic       uns;
      logic       csr;
      logic       ecall;
      logic       mret;
      logic       md;
      logic       ill;
   } dec_t;

   typedef struct {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
   } ent_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            in_valid = 1'b0;
   logic            flush = 1'b0;
   logic            out_ready = 1'b0;
   logic [31:0]     in_inst = '0;
   logic [XLEN-1:0] in_pc = '0;
   int              checks = 0;
   int              failures = 0;

   ent_t        q[$];
   bit          m_halt = 1'b0;
   logic [31:0] m_cnt = '0;

   ysyx_23060240_idu_pipe_if #(.XLEN(XLEN)) bus ();
   ysyx_23060240_idu_pipe_if #(.XLEN(XLEN)) bus_m ();

   assign bus.in_valid    = in_valid;
   assign bus.in_inst     = in_inst;
   assign bus.in_pc       = in_pc;
   assign bus.flush       = flush;
   assign bus.out_ready   = out_ready;
   assign bus_m.in_valid  = in_valid;
   assign bus_m.in_inst   = in_inst;
   assign bus_m.in_pc     = in_pc;
   assign bus_m.flush     = flush;
   assign bus_m.out_ready = out_ready;

   ysyx_23060240_idu_pipe #(
      .XLEN(XLEN), .DEPTH(DEPTH), .EN_M(1'b0)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   ysyx_23060240_idu_pipe #(
      .XLEN(XLEN), .DEPTH(DEPTH), .EN_M(1'b1)
   ) u_dut_m (
      .clk(clk), .rst_n(rst_n), .bus(bus_m)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Decode rules written per mnemonic family.
   function automatic dec_t ref_dec(input logic [31:0] i, input bit en_m);
      dec_t d = '0;
      int f3 = int'(i[14:12]);
      logic [6:0] f7 = i[31:25];
      bit ok = 1'b1;
      case (i[6:0])
         7'h37: begin d.w_en = 1; d.w_sel = 2; d.alu = 14; end
         7'h17: begin d.w_en = 1; d.w_sel = 2; end
         7'h6f: begin d.w_en = 1; d.w_sel = 1; d.jump = 1; end
         7'h67: begin
            ok = (f3 == 0); d.w_en = 1; d.w_sel = 1; d.jump = 1;
         end
         7'h63: begin
            ok = !(f3 == 2 || f3 == 3);
            d.br = 3'(f3 < 4 ? f3 + 1 : f3 - 1);
         end
         7'h03: begin
            ok = (f3 inside {0, 1, 2, 4, 5});
            d.rd = 1; d.w_en = 1; d.w_sel = 3;
            d.size = 2'(f3 % 4); d.uns = (f3 >= 4);
         end
         7'h23: begin ok = (f3 < 3); d.wr = 1; d.size = 2'(f3); end
         7'h13: begin
            d.w_en = 1; d.w_sel = 2;
            if (f3 == 1) ok = (f7 == 0);
            if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
            d.alu = 4'(f3 + ((f3 == 5 && f7 == 7'h20) ? 8 : 0));
         end
         7'h33: begin
            d.w_en = 1; d.w_sel = 2;
            if (f7 == 7'h01) begin
               ok = en_m; d.md = en_m; d.alu = 4'(f3);
            end else if (f7 == 7'h20) begin
               ok = (f3 == 0 || f3 == 5); d.alu = 4'(f3 + 8);
            end else begin
               ok = (f7 == 0); d.alu = 4'(f3);
            end
         end
         7'h73: begin
            if (i == 32'h73) d.ecall = 1;
            else if (i == 32'h3020_0073) d.mret = 1;
            else if (i == EBREAK) ok = 1;
            else if (f3 == 1 || f3 == 2) begin
               d.csr = 1; d.w_en = 1; d.w_sel = 4;
               d.alu = (f3 == 1) ? 4'd8 : 4'd6;
            end else ok = 0;
         end
         default: ok = 0;
      endcase
      if (!ok) begin d = '0; d.ill = 1; end
      return d;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w = $urandom;
      logic [6:0] ops [10];
      int k = $urandom_range(0, 10);
      ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
              7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
      if (k < 10) w[6:0] = ops[k];
      if (w[6:0] == 7'h13 || w[6:0] == 7'h33) begin
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
         endcase
      end
      if (w[6:0] == 7'h73) begin
         case ($urandom_range(0, 3))
            0: w = 32'h73;
            1: w = 32'h3020_0073;
            default: ;
         endcase
      end
      if (w == EBREAK) w = 32'h73;
      return w;
   endfunction

   task automatic chk_dec(input string tag, input dec_t o, input dec_t e);
      if (e.ill) begin
         chk({tag, ".illegal"}, 32'(o.ill), 1);
         chk({tag, ".w_en"}, 32'(o.w_en), 0);
         chk({tag, ".mem"}, 32'({o.rd, o.wr}), 0);
         chk({tag, ".jump"}, 32'(o.jump), 0);
         chk({tag, ".csr"}, 32'(o.csr), 0);
         chk({tag, ".branch"}, 32'(o.br), 0);
         chk({tag, ".muldiv"}, 32'(o.md), 0);
      end else begin
         chk({tag, ".bundle"}, 32'(o), 32'(e));
      end
   endtask

   task automatic cycle();
      bit e_ready;
      bit e_valid;
      bit e_push;
      bit e_pop;
      dec_t o0;
      dec_t o1;
      @(negedge clk);
      e_ready = (q.size() < DEPTH) && !flush && !m_halt;
      e_valid = (q.size() != 0) && !flush && !m_halt;
      chk("in_ready", 32'(bus.in_ready), 32'(e_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
      chk("m.in_ready", 32'(bus_m.in_ready), 32'(e_ready));
      chk("m.out_valid", 32'(bus_m.out_valid), 32'(e_valid));
      chk("halt", 32'(bus.out_halt), 32'(m_halt));
      chk("dec_cnt", bus.out_dec_cnt, m_cnt);
      if (e_valid) begin
         o0 = {bus.out_alu_func, bus.out_w_en, bus.out_w_sel,
               bus.out_branch_type, bus.out_jump,
               bus.out_mem_rd_en, bus.out_mem_wr_en,
               bus.out_mem_size, bus.out_mem_unsigned,
               bus.out_csr_en, bus.out_ecall, bus.out_mret,
               bus.out_is_muldiv, bus.out_illegal};
         o1 = {bus_m.out_alu_func, bus_m.out_w_en, bus_m.out_w_sel,
               bus_m.out_branch_type, bus_m.out_jump,
               bus_m.out_mem_rd_en, bus_m.out_mem_wr_en,
               bus_m.out_mem_size, bus_m.out_mem_unsigned,
               bus_m.out_csr_en, bus_m.out_ecall, bus_m.out_mret,
               bus_m.out_is_muldiv, bus_m.out_illegal};
         chk("out_pc", bus.out_pc, q[0].pc);
         chk("out_inst", bus.out_inst, q[0].inst);
         chk_dec("dec", o0, ref_dec(q[0].inst, 1'b0));
         chk_dec("dec_m", o1, ref_dec(q[0].inst, 1'b1));
      end
      e_push = in_valid && e_ready;
      e_pop  = e_valid && out_ready;
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         m_halt = 1'b0;
         m_cnt  = '0;
      end else if (flush) begin
         q.delete();
      end else begin
         if (e_pop) begin
            if (q[0].inst == EBREAK) m_halt = 1'b1;
            void'(q.pop_front());
            m_cnt++;
         end
         if (e_push) q.push_back('{in_pc, in_inst});
      end
      #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      cycle();
      chk("rst.in_ready", 32'(bus.in_ready), 1);
      chk("rst.out_valid", 32'(bus.out_valid), 0);
      chk("rst.dec_cnt", bus.out_dec_cnt, 0);
      rst_n = 1'b1;

      in_valid = 1; in_inst = 32'h0050_0093; in_pc = 32'h8000_0000;
      cycle();
      in_valid = 0;
      chk("addi.valid", 32'(bus.out_valid), 1);
      chk("addi.pc", bus.out_pc, 32'h8000_0000);
      chk("addi.alu", 32'(bus.out_alu_func), 0);
      chk("addi.w_sel", 32'(bus.out_w_sel), 2);
      chk("addi.w_en", 32'(bus.out_w_en), 1);
      chk("addi.illegal", 32'(bus.out_illegal), 0);
      out_ready = 1; cycle(); out_ready = 0;

      in_valid = 1; in_inst = 32'h0010_0113; in_pc = 32'h100;
      cycle();
      in_inst = 32'h0020_0193; in_pc = 32'h104;
      cycle();
      chk("full.in_ready", 32'(bus.in_ready), 0);
      in_inst = 32'h0030_0213; in_pc = 32'h108;
      cycle();
      chk("held.in_ready", 32'(bus.in_ready), 0);
      chk("held.head", bus.out_inst, 32'h0010_0113);
      out_ready = 1;
      cycle();
      chk("pop1.in_ready", 32'(bus.in_ready), 1);
      chk("pop1.head", bus.out_inst, 32'h0020_0193);
      cycle();
      chk("pop2.head", bus.out_inst, 32'h0030_0213);
      in_valid = 0;
      cycle();
      chk("drain.dec_cnt", bus.out_dec_cnt, 4);
      chk("drain.valid", 32'(bus.out_valid), 0);

      out_ready = 0; in_valid = 1; in_inst = 32'h0040_0293; in_pc = 32'h200;
      cycle();
      in_inst = 32'h0050_0313; in_pc = 32'h204; out_ready = 1;
      cycle();
      chk("pp.valid", 32'(bus.out_valid), 1);
      chk("pp.head", bus.out_inst, 32'h0050_0313);
      in_valid = 0;
      cycle();
      chk("pp.empty", 32'(bus.out_valid), 0);

      out_ready = 0; in_valid = 1; in_inst = 32'h0060_0393; in_pc = 32'h300;
      cycle();
      in_inst = 32'h0070_0413; in_pc = 32'h304;
      cycle();
      in_inst = 32'h0080_0493; in_pc = 32'h308; flush = 1;
      cycle();
      flush = 0; in_valid = 0;
      chk("flush.valid", 32'(bus.out_valid), 0);
      chk("flush.dec_cnt", bus.out_dec_cnt, 6);
      cycle();
      chk("flush.drop", 32'(bus.out_valid), 0);

      in_valid = 1; in_inst = 32'h0220_8033; in_pc = 32'h400;
      cycle();
      in_valid = 0;
      chk("mul.ill_m0", 32'(bus.out_illegal), 1);
      chk("mul.md_m0", 32'(bus.out_is_muldiv), 0);
      chk("mul.md_m1", 32'(bus_m.out_is_muldiv), 1);
      chk("mul.wsel_m1", 32'(bus_m.out_w_sel), 2);
      chk("mul.ill_m1", 32'(bus_m.out_illegal), 0);
      out_ready = 1; cycle(); out_ready = 0;

      in_valid = 1; in_inst = 32'hFFFF_FFFF; in_pc = 32'h404;
      cycle();
      in_valid = 0;
      chk("ones.illegal", 32'(bus.out_illegal), 1);
      chk("ones.w_en", 32'(bus.out_w_en), 0);
      out_ready = 1; cycle();

      for (int n = 0; n < 600; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_inst   = rand_inst();
         in_pc     = $urandom & 32'hFFFF_FFFC;
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         cycle();
      end
      flush = 0; in_valid = 0; out_ready = 1;
      repeat (3) cycle();

      out_ready = 0; in_valid = 1; in_inst = EBREAK; in_pc = 32'h500;
      cycle();
      in_inst = 32'h0050_0093; in_pc = 32'h504;
      cycle();
      out_ready = 1;
      cycle();
      chk("halt.set", 32'(bus.out_halt), 1);
      chk("halt.in_ready", 32'(bus.in_ready), 0);
      chk("halt.out_valid", 32'(bus.out_valid), 0);
      repeat (3) cycle();
      chk("halt.sticky", 32'(bus.out_halt), 1);

      rst_n = 0;
      q.delete(); m_halt = 1'b0; m_cnt = '0;
      #1;
      chk("rst2.halt", 32'(bus.out_halt), 0);
      chk("rst2.in_ready", 32'(bus.in_ready), 1);
      chk("rst2.dec_cnt", bus.out_dec_cnt, 0);
      in_valid = 0;
      cycle();
      rst_n = 1;
      cycle();
      chk("rst2.empty", 32'(bus.out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
